// File: rtl/counter_game_pkg.sv
// Shared types for the parametrised counter game.
//   who_e  : last game result reported on the `who` output
//   ctrl_e : 2-bit step control code (direction in bit 1, magnitude in bit 0)
package counter_game_pkg;

  typedef enum logic [1:0] {
    WHO_NONE   = 2'b00,
    WHO_LOSER  = 2'b01,
    WHO_WINNER = 2'b10
  } who_e;

  typedef enum logic [1:0] {
    CTRL_UP_S = 2'b00,
    CTRL_UP_L = 2'b01,
    CTRL_DN_S = 2'b10,
    CTRL_DN_L = 2'b11
  } ctrl_e;

endpackage

// File: rtl/counter_game_param_if.sv
// Bus bundle for the counter game (clock and reset stay plain ports).
//   master : drives enable/control/load/init_value/sat_mode, observes results
//   slave  : the game core; drives counter, pulses, who and both scores
interface counter_game_param_if #(
  parameter int WIDTH       = 4,
  parameter int SCORE_WIDTH = 4
);
  logic                   enable;
  logic [1:0]             control;
  logic                   load;
  logic [WIDTH-1:0]       init_value;
  logic                   sat_mode;
  logic [WIDTH-1:0]       counter;
  logic                   winner;
  logic                   loser;
  logic                   gameover;
  logic [1:0]             who;
  logic [SCORE_WIDTH-1:0] winner_count;
  logic [SCORE_WIDTH-1:0] loser_count;

  modport master (
    output enable, control, load, init_value, sat_mode,
    input  counter, winner, loser, gameover, who, winner_count, loser_count
  );

  modport slave (
    input  enable, control, load, init_value, sat_mode,
    output counter, winner, loser, gameover, who, winner_count, loser_count
  );
endinterface

// File: rtl/counter_game_step.sv
// Combinational next-value unit for the game counter.
//   counter  : current value
//   control  : step code (up/down, small/large)
//   sat_mode : 0 = wrap modulo 2**WIDTH, 1 = clamp at 0 / MAX
//   stepped  : value after one step
module counter_game_step
  import counter_game_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int STEP_SMALL = 1,
  parameter int STEP_LARGE = 2
) (
  input  logic [WIDTH-1:0] counter,
  input  logic [1:0]       control,
  input  logic             sat_mode,
  output logic [WIDTH-1:0] stepped
);

  localparam logic [WIDTH:0] STEP_S = (WIDTH+1)'(STEP_SMALL);
  localparam logic [WIDTH:0] STEP_L = (WIDTH+1)'(STEP_LARGE);

  // Bit WIDTH of the widened sum is the carry (up) or borrow (down);
  // either one means the true result left the 0..MAX range.
  function automatic logic [WIDTH-1:0] saturate(input logic [WIDTH:0] sum,
                                                input logic up,
                                                input logic sat);
    if (sat && sum[WIDTH]) return up ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
    return sum[WIDTH-1:0];
  endfunction

  logic [WIDTH:0] sum;
  logic           up;

  always_comb begin
    sum = {1'b0, counter};
    up  = 1'b1;
    case (ctrl_e'(control))
      CTRL_UP_S: begin sum = {1'b0, counter} + STEP_S; up = 1'b1; end
      CTRL_UP_L: begin sum = {1'b0, counter} + STEP_L; up = 1'b1; end
      CTRL_DN_S: begin sum = {1'b0, counter} - STEP_S; up = 1'b0; end
      CTRL_DN_L: begin sum = {1'b0, counter} - STEP_L; up = 1'b0; end
      default:   begin sum = {1'b0, counter};          up = 1'b1; end
    endcase
    stepped = saturate(sum, up, sat_mode);
  end

endmodule

// File: rtl/counter_game_param.sv
// Parametrised single-player counter game.
//   clock   : rising-edge clock
//   reset_n : synchronous active-low reset
//   bus     : slave side of counter_game_param_if (controls in, counter,
//             winner/loser/gameover pulses, who and both scores out)
// After every scoring edge one "release" edge follows on which no event is
// detected, so a counter parked at 0 or MAX scores every second cycle.
module counter_game_param
  import counter_game_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int STEP_SMALL  = 1,
  parameter int STEP_LARGE  = 2,
  parameter int SCORE_WIDTH = 4,
  parameter int SCORE_LIMIT = 2**SCORE_WIDTH-1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  counter_game_param_if.slave   bus
);

  localparam logic [WIDTH-1:0]       MAX   = {WIDTH{1'b1}};
  localparam logic [SCORE_WIDTH-1:0] LIMIT = SCORE_WIDTH'(SCORE_LIMIT);
  localparam logic [SCORE_WIDTH-1:0] ONE   = SCORE_WIDTH'(1);

  logic [WIDTH-1:0]       counter_q, counter_d;
  logic [SCORE_WIDTH-1:0] wcount_q, wcount_d;
  logic [SCORE_WIDTH-1:0] lcount_q, lcount_d;
  logic                   winner_q, winner_d;
  logic                   loser_q, loser_d;
  logic                   gameover_q, gameover_d;
  logic                   hold_q, hold_d;
  who_e                   who_q, who_d;

  logic [WIDTH-1:0]       stepped;
  logic [WIDTH-1:0]       nxt;

  counter_game_step #(
    .WIDTH      (WIDTH),
    .STEP_SMALL (STEP_SMALL),
    .STEP_LARGE (STEP_LARGE)
  ) u_step (
    .counter  (counter_q),
    .control  (bus.control),
    .sat_mode (bus.sat_mode),
    .stepped  (stepped)
  );

  assign nxt = bus.load ? bus.init_value : stepped;

  always_comb begin
    counter_d  = counter_q;
    wcount_d   = wcount_q;
    lcount_d   = lcount_q;
    who_d      = who_q;
    winner_d   = 1'b0;
    loser_d    = 1'b0;
    gameover_d = 1'b0;
    hold_d     = 1'b0;

    if (gameover_q) begin
      // Restart edge: everything but `who` returns to zero.
      counter_d = '0;
      wcount_d  = '0;
      lcount_d  = '0;
    end else if (bus.enable) begin
      counter_d = nxt;
      if (!hold_q) begin
        if (nxt == '0) begin
          loser_d  = 1'b1;
          hold_d   = 1'b1;
          lcount_d = lcount_q + ONE;
          if (lcount_q + ONE == LIMIT) begin
            gameover_d = 1'b1;
            who_d      = WHO_LOSER;
          end
        end else if (nxt == MAX) begin
          winner_d = 1'b1;
          hold_d   = 1'b1;
          wcount_d = wcount_q + ONE;
          if (wcount_q + ONE == LIMIT) begin
            gameover_d = 1'b1;
            who_d      = WHO_WINNER;
          end
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      counter_q  <= '0;
      wcount_q   <= '0;
      lcount_q   <= '0;
      winner_q   <= 1'b0;
      loser_q    <= 1'b0;
      gameover_q <= 1'b0;
      hold_q     <= 1'b0;
      who_q      <= WHO_NONE;
    end else begin
      counter_q  <= counter_d;
      wcount_q   <= wcount_d;
      lcount_q   <= lcount_d;
      winner_q   <= winner_d;
      loser_q    <= loser_d;
      gameover_q <= gameover_d;
      hold_q     <= hold_d;
      who_q      <= who_d;
    end
  end

  assign bus.counter      = counter_q;
  assign bus.winner       = winner_q;
  assign bus.loser        = loser_q;
  assign bus.gameover     = gameover_q;
  assign bus.who          = who_q;
  assign bus.winner_count = wcount_q;
  assign bus.loser_count  = lcount_q;

endmodule
